// File: rtl/param_boot_loader_pkg.sv
// Shared constants and types for the UART boot loader: protocol bytes,
// FSM state encoding and the bytes-per-word helper.
package param_boot_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_RESP,
        S_SCAN_RD,
        S_SCAN_TX
    } state_t;

    function automatic int bytes_per_word(input int data_w);
        return (data_w + 7) / 8;
    endfunction

endpackage

// File: rtl/param_boot_loader_uart_core.sv
// 8N1 UART: synchronised receiver with framing-error flag and a
// single-byte transmitter with a busy flag. ce=0 freezes everything.
module uart_core #(
    parameter int BAUD_DIV = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_rx_ferr,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy,
    output logic       o_tx
);

    localparam int CW = $clog2(BAUD_DIV);

    logic          r_rx_meta, r_rx_sync, r_rx_prev, r_rx_active;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_active <= 1'b0;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_sh     <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_data   <= '0;
            o_rx_ferr   <= 1'b0;
        end else if (i_ce) begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            o_rx_valid <= 1'b0;
            if (!r_rx_active) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_active <= 1'b1;
                    r_rx_cnt    <= CW'(BAUD_DIV / 2 - 1);
                    r_rx_bit    <= '0;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end else begin
                r_rx_cnt <= CW'(BAUD_DIV - 1);
                r_rx_bit <= r_rx_bit + 1'b1;
                if (r_rx_bit == 4'd0) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (r_rx_sync)
                        r_rx_active <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_active <= 1'b0;
                    o_rx_valid  <= 1'b1;
                    o_rx_ferr   <= !r_rx_sync;
                    o_rx_data   <= r_rx_sh;
                end else begin
                    r_rx_sh <= {r_rx_sync, r_rx_sh[7:1]};
                end
            end
        end
    end

    logic          r_tx_busy;
    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_busy <= 1'b0;
            r_tx_sh   <= '1;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
        end else if (i_ce) begin
            if (!r_tx_busy) begin
                if (i_tx_start) begin
                    r_tx_busy <= 1'b1;
                    r_tx_sh   <= {1'b1, i_tx_data, 1'b0};
                    r_tx_cnt  <= CW'(BAUD_DIV - 1);
                    r_tx_bit  <= '0;
                end
            end else if (r_tx_cnt != '0) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
                r_tx_cnt <= CW'(BAUD_DIV - 1);
                if (r_tx_bit == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                    r_tx_bit <= r_tx_bit + 1'b1;
                end
            end
        end
    end

    // A start request counts as busy so the caller never issues two in a row.
    assign o_tx_busy = r_tx_busy | i_tx_start;
    assign o_tx      = r_tx_sh[0];

endmodule

// File: rtl/param_boot_loader.sv
// UART boot loader: loads a framed, XOR-checked image into program RAM
// while holding the core in boot, and can dump the whole RAM over TX.
module param_boot_loader
    import param_boot_loader_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int BAUD_DIV    = 434,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ce,
    input  logic              i_rx,
    output logic              o_tx,
    input  logic              i_scan_memory,
    output logic              o_boot,
    output logic [DATA_W-1:0] o_ram_out,
    input  logic [DATA_W-1:0] i_ram_in,
    output logic [ADDR_W-1:0] o_ram_adr,
    output logic              o_ram_rw,
    output logic              o_ram_enable,
    output logic              o_done,
    output logic              o_error
);

    localparam int BYTES = bytes_per_word(DATA_W);
    localparam int WW    = BYTES * 8;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic       w_rx_valid, w_rx_ferr, w_tx_busy;
    logic [7:0] w_rx_data;
    logic       r_tx_start;
    logic [7:0] r_tx_data;

    uart_core #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ce       (i_ce),
        .i_rx       (i_rx),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .o_rx_ferr  (w_rx_ferr),
        .i_tx_start (r_tx_start),
        .i_tx_data  (r_tx_data),
        .o_tx_busy  (w_tx_busy),
        .o_tx       (o_tx)
    );

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_words_left;
    logic [2:0]        r_byte_idx;
    logic [WW-1:0]     r_word;
    logic [7:0]        r_chk;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_scan_cap;

    logic [WW-1:0] w_word_shift;
    logic          w_waiting, w_tmo_hit, w_abort;

    assign w_word_shift = (r_word << 8) | WW'(w_rx_data);
    assign w_waiting    = (r_state == S_CNT) || (r_state == S_DATA) || (r_state == S_CHK);
    assign w_tmo_hit    = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
    // Broken stop bit or a silent line both kill the frame with a NAK.
    assign w_abort      = w_waiting && (w_rx_valid ? w_rx_ferr : w_tmo_hit);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_chk        <= '0;
            r_tmo        <= '0;
            r_scan_cap   <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            o_boot       <= 1'b0;
            o_ram_out    <= '0;
            o_ram_adr    <= '0;
            o_ram_rw     <= 1'b0;
            o_ram_enable <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
        end else if (i_ce) begin
            r_tx_start   <= 1'b0;
            o_ram_enable <= 1'b0;
            o_done       <= 1'b0;
            if (w_waiting)
                r_tmo <= w_rx_valid ? '0 : r_tmo + 1'b1;
            else
                r_tmo <= '0;

            if (w_abort) begin
                r_tx_start <= 1'b1;
                r_tx_data  <= NAK_BYTE;
                o_error    <= 1'b1;
                r_state    <= S_RESP;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_scan_memory) begin
                            r_state      <= S_SCAN_RD;
                            o_boot       <= 1'b1;
                            r_addr       <= '0;
                            r_scan_cap   <= 1'b0;
                            o_ram_enable <= 1'b1;
                            o_ram_rw     <= 1'b0;
                            o_ram_adr    <= '0;
                        end else if (w_rx_valid && !w_rx_ferr && w_rx_data == SYNC_BYTE) begin
                            r_state <= S_CNT;
                            o_boot  <= 1'b1;
                            o_error <= 1'b0;
                        end
                    end
                    S_CNT: begin
                        if (w_rx_valid) begin
                            r_words_left <= w_rx_data;
                            r_addr       <= '0;
                            r_chk        <= '0;
                            r_byte_idx   <= '0;
                            r_word       <= '0;
                            r_state      <= (w_rx_data == 8'd0) ? S_CHK : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_rx_valid) begin
                            r_chk  <= r_chk ^ w_rx_data;
                            r_word <= w_word_shift;
                            if (r_byte_idx == 3'(BYTES - 1)) begin
                                r_byte_idx   <= '0;
                                r_state      <= S_WRITE;
                                o_ram_enable <= 1'b1;
                                o_ram_rw     <= 1'b1;
                                o_ram_adr    <= r_addr;
                                o_ram_out    <= DATA_W'(w_word_shift);
                            end else begin
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_addr       <= r_addr + 1'b1;
                        r_words_left <= r_words_left - 1'b1;
                        r_state      <= (r_words_left == 8'd1) ? S_CHK : S_DATA;
                    end
                    S_CHK: begin
                        if (w_rx_valid) begin
                            r_tx_start <= 1'b1;
                            r_state    <= S_RESP;
                            if (w_rx_data == r_chk) begin
                                r_tx_data <= ACK_BYTE;
                                o_done    <= 1'b1;
                            end else begin
                                r_tx_data <= NAK_BYTE;
                                o_error   <= 1'b1;
                            end
                        end
                    end
                    S_RESP: begin
                        if (!w_tx_busy) begin
                            o_boot  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_SCAN_RD: begin
                        // First cycle is the read strobe, second captures ram_in.
                        if (!r_scan_cap) begin
                            r_scan_cap <= 1'b1;
                        end else begin
                            r_scan_cap <= 1'b0;
                            r_word     <= WW'(i_ram_in);
                            r_byte_idx <= '0;
                            r_state    <= S_SCAN_TX;
                        end
                    end
                    S_SCAN_TX: begin
                        if (!w_tx_busy) begin
                            if (r_byte_idx != 3'(BYTES)) begin
                                r_tx_start <= 1'b1;
                                r_tx_data  <= r_word[WW-1 -: 8];
                                r_word     <= r_word << 8;
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end else if (r_addr == '1) begin
                                o_boot  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_addr       <= r_addr + 1'b1;
                                o_ram_enable <= 1'b1;
                                o_ram_rw     <= 1'b0;
                                o_ram_adr    <= r_addr + 1'b1;
                                r_state      <= S_SCAN_RD;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_boot_loader.sv
// Scoreboard bench for param_boot_loader: RAM model, TX byte decoder and
// per-scenario tasks checking loads, NAKs, scan, timeout, wrap, reset and ce.
module tb_param_boot_loader;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 6;
    localparam int BAUD_DIV    = 8;
    localparam int TIMEOUT_CYC = 2000;
    localparam int DEPTH       = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ce = 1'b1;
    logic              rx = 1'b1;
    logic              scan_memory = 1'b0;
    logic              tx, boot, ram_rw, ram_enable, done, error;
    logic [DATA_W-1:0] ram_out;
    logic [DATA_W-1:0] ram_in = '0;
    logic [ADDR_W-1:0] ram_adr;

    always #5 clk = ~clk;

    param_boot_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BAUD_DIV(BAUD_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ce          (ce),
        .i_rx          (rx),
        .o_tx          (tx),
        .i_scan_memory (scan_memory),
        .o_boot        (boot),
        .o_ram_out     (ram_out),
        .i_ram_in      (ram_in),
        .o_ram_adr     (ram_adr),
        .o_ram_rw      (ram_rw),
        .o_ram_enable  (ram_enable),
        .o_done        (done),
        .o_error       (error)
    );

    int n_vec = 0;
    int n_err = 0;
    int read_cnt = 0;
    int done_cnt = 0;
    logic [7:0]          exp_tx[$];
    logic [ADDR_W+DATA_W-1:0] exp_wr[$];
    logic [DATA_W-1:0]   mem[DEPTH];
    logic [ADDR_W+DATA_W-1:0] wr_e;
    logic                done_prev = 1'b0;
    logic [7:0]          mon_byte, tx_e;

    // Program RAM: registered read, write on strobe.
    always @(posedge clk) begin
        if (!rst && ram_enable) begin
            if (ram_rw) mem[ram_adr] = ram_out;
            else        ram_in <= mem[ram_adr];
        end
    end

    // Write/read/done observer, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_enable && ram_rw) begin
                n_vec++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL ram_write: got adr=%h data=%h, required no write", ram_adr, ram_out);
                end else begin
                    wr_e = exp_wr.pop_front();
                    if ({ram_adr, ram_out} !== wr_e) begin
                        n_err++;
                        $display("FAIL ram_write: got adr=%h data=%h, required adr=%h data=%h",
                                 ram_adr, ram_out, wr_e[DATA_W +: ADDR_W], wr_e[DATA_W-1:0]);
                    end else
                        $display("write adr=%h data=%h ok", ram_adr, ram_out);
                end
            end
            if (ram_enable && !ram_rw) read_cnt++;
            if (done) begin
                done_cnt++;
                n_vec++;
                if (done_prev) begin
                    n_err++;
                    $display("FAIL done_width: got done high 2 cycles, required 1-cycle pulse");
                end
            end
            done_prev = done;
        end else
            done_prev = 1'b0;
    end

    // TX decoder: poll for a start bit, then sample mid-bit.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (tx === 1'b0 && !rst) begin
                repeat (BAUD_DIV / 2) begin @(posedge clk); #1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) begin @(posedge clk); #1; end
                    mon_byte[i] = tx;
                end
                repeat (BAUD_DIV) begin @(posedge clk); #1; end
                n_vec++;
                if (tx !== 1'b1) begin
                    n_err++;
                    $display("FAIL tx_stop: got stop bit %b, required 1", tx);
                end else if (exp_tx.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_byte: got %h, required no byte", mon_byte);
                end else begin
                    tx_e = exp_tx.pop_front();
                    if (mon_byte !== tx_e) begin
                        n_err++;
                        $display("FAIL tx_byte: got %h, required %h", mon_byte, tx_e);
                    end else
                        $display("tx byte %h ok", mon_byte);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        wait_cycles(BAUD_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BAUD_DIV);
        end
        rx = 1'b1;
        wait_cycles(BAUD_DIV);
    endtask

    task automatic wait_boot_low(input int max_cyc, output bit ok);
        int k = 0;
        while (boot !== 1'b0 && k < max_cyc) begin
            wait_cycles(1);
            k++;
        end
        ok = (boot === 1'b0);
        wait_cycles(4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        n_vec++;
        if ({tx, boot, ram_enable, ram_rw, done, error} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got tx/boot/en/rw/done/err=%b, required 100000",
                     {tx, boot, ram_enable, ram_rw, done, error});
        end
        n_vec++;
        if ({ram_adr, ram_out} !== '0) begin
            n_err++;
            $display("FAIL reset_ram: got adr=%h out=%h, required 0/0", ram_adr, ram_out);
        end
        rst = 1'b0;
        wait_cycles(5);
        $display("reset checked");
    endtask

    task automatic test_load_ack();
        bit ok;
        exp_wr.push_back({6'd0, 16'h1234});
        exp_wr.push_back({6'd1, 16'hABCD});
        exp_tx.push_back(8'h06);
        done_cnt = 0;
        send_byte(8'hA5);
        wait_cycles(3);
        n_vec++;
        if (boot !== 1'b1) begin
            n_err++;
            $display("FAIL load_boot_high: got boot=%b, required 1", boot);
        end
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h40);
        wait_boot_low(2000, ok);
        n_vec++;
        if (!ok || done_cnt != 1 || error !== 1'b0 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL load_ack: got boot_low=%0d done=%0d err=%b pend_tx=%0d pend_wr=%0d, required 1 1 0 0 0",
                     ok, done_cnt, error, exp_tx.size(), exp_wr.size());
        end
        $display("load_ack frame done");
    endtask

    task automatic test_nak_then_clear();
        bit ok;
        exp_wr.push_back({6'd0, 16'h1234});
        exp_wr.push_back({6'd1, 16'hABCD});
        exp_tx.push_back(8'h15);
        done_cnt = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h41);
        wait_boot_low(2000, ok);
        n_vec++;
        if (!ok || done_cnt != 0 || error !== 1'b1 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL nak: got boot_low=%0d done=%0d err=%b pend_tx=%0d pend_wr=%0d, required 1 0 1 0 0",
                     ok, done_cnt, error, exp_tx.size(), exp_wr.size());
        end
        exp_tx.push_back(8'h06);
        send_byte(8'hA5);
        wait_cycles(3);
        n_vec++;
        if (error !== 1'b0) begin
            n_err++;
            $display("FAIL error_clear_on_sync: got error=%b, required 0", error);
        end
        send_byte(8'h00); send_byte(8'h00);
        wait_boot_low(2000, ok);
        n_vec++;
        if (!ok || done_cnt != 1 || error !== 1'b0 || exp_tx.size() != 0) begin
            n_err++;
            $display("FAIL empty_ack: got boot_low=%0d done=%0d err=%b pend_tx=%0d, required 1 1 0 0",
                     ok, done_cnt, error, exp_tx.size());
        end
        $display("nak and empty frame done");
    endtask

    task automatic test_scan();
        bit ok;
        int k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 16'(i);
            exp_tx.push_back(8'h00);
            exp_tx.push_back(8'(i));
        end
        read_cnt = 0;
        scan_memory = 1'b1;
        while (boot !== 1'b1 && k < 10) begin wait_cycles(1); k++; end
        scan_memory = 1'b0;
        wait_boot_low(20000, ok);
        n_vec++;
        if (!ok || read_cnt != DEPTH || exp_tx.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL scan: got boot_low=%0d reads=%0d pend_tx=%0d pend_wr=%0d, required 1 64 0 0",
                     ok, read_cnt, exp_tx.size(), exp_wr.size());
        end
        $display("scan of %0d words done", read_cnt);
    endtask

    task automatic test_timeout();
        bit ok;
        exp_tx.push_back(8'h15);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h12);
        wait_cycles(TIMEOUT_CYC / 2);
        n_vec++;
        if (boot !== 1'b1 || exp_tx.size() != 1) begin
            n_err++;
            $display("FAIL timeout_early: got boot=%b pend_tx=%0d, required 1 1", boot, exp_tx.size());
        end
        wait_boot_low(TIMEOUT_CYC + 500, ok);
        n_vec++;
        if (!ok || error !== 1'b1 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL timeout: got boot_low=%0d err=%b pend_tx=%0d pend_wr=%0d, required 1 1 0 0",
                     ok, error, exp_tx.size(), exp_wr.size());
        end
        $display("timeout abort done");
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0]  chk = 8'h00;
        logic [15:0] w;
        done_cnt = 0;
        send_byte(8'hA5);
        send_byte(8'h41);
        for (int k = 0; k <= 64; k++) begin
            w = 16'h5A00 | 16'(k);
            exp_wr.push_back({6'(k), w});
            chk = chk ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        exp_tx.push_back(8'h06);
        send_byte(chk);
        wait_boot_low(2000, ok);
        n_vec++;
        if (!ok || done_cnt != 1 || mem[0] !== 16'h5A40 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL wrap: got boot_low=%0d done=%0d mem0=%h pend_tx=%0d pend_wr=%0d, required 1 1 5a40 0 0",
                     ok, done_cnt, mem[0], exp_tx.size(), exp_wr.size());
        end
        $display("65-word wrap frame done");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h12);
        rx = 1'b0;
        wait_cycles(20);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({tx, boot, ram_enable, ram_rw, done, error} !== 6'b100000 || {ram_adr, ram_out} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: got tx/boot/en/rw/done/err=%b adr=%h out=%h, required 100000 0 0",
                     {tx, boot, ram_enable, ram_rw, done, error}, ram_adr, ram_out);
        end
        rx = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(200);
        n_vec++;
        if (boot !== 1'b0 || tx !== 1'b1 || error !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_after: got boot=%b tx=%b err=%b, required 0 1 0", boot, tx, error);
        end
        $display("mid-frame reset done");
    endtask

    task automatic test_ce_pause();
        bit ok;
        exp_wr.push_back({6'd0, 16'h0001});
        exp_wr.push_back({6'd1, 16'h0002});
        exp_tx.push_back(8'h06);
        done_cnt = 0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        ce = 1'b0;
        wait_cycles(50);
        n_vec++;
        if (boot !== 1'b1 || ram_enable !== 1'b0 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL ce_hold: got boot=%b en=%b tx=%b, required 1 0 1", boot, ram_enable, tx);
        end
        ce = 1'b1;
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h03);
        wait_boot_low(2000, ok);
        n_vec++;
        if (!ok || done_cnt != 1 || error !== 1'b0 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
            n_err++;
            $display("FAIL ce_pause_ack: got boot_low=%0d done=%0d err=%b pend_tx=%0d pend_wr=%0d, required 1 1 0 0 0",
                     ok, done_cnt, error, exp_tx.size(), exp_wr.size());
        end
        $display("ce pause frame done");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_load_ack();
        test_nak_then_clear();
        test_scan();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_ce_pause();
        wait_cycles(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
